// File: rtl/serial_adder_if.sv
// Serial adder bus: start/operands in, result/status out.
// Master drives operands, slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first,
// WIDTH run cycles, registered sum/cout/busy/done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             s_bit;
  logic             c_d;
  logic [WIDTH-1:0] res_d;

  // Single full-adder cell on the operand LSBs.
  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_d   = (a_q[0] & b_q[0]) |
                 (a_q[0] & carry_q) |
                 (b_q[0] & carry_q);
  assign res_d = {s_bit, res_q[WIDTH-1:1]};

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Control FSM plus the serial datapath it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= res_d;
            cout_q  <= c_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
